// File: rtl/weight_stream_reader_pkg.sv
// Shared definitions for the weight stream reader.
// Holds the sweep FSM state encoding and the default geometry of one
// weight block RAM (28 words of 16 bits, 5-bit address).
package weight_stream_pkg;

  localparam int WEIGHT_DEPTH = 28;
  localparam int WEIGHT_AW    = 5;
  localparam int WEIGHT_DW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/weight_stream_reader_if.sv
// Bundle of every signal the weight stream reader exchanges with the outside
// world, apart from clock and reset.
//   start/busy/done          : sweep control and status
//   addr/en/we/di/ram_do     : read port of the weight block RAM
//   w_data/w_idx/w_last      : head word of the outgoing weight stream
//   w_valid/w_ready          : stream handshake toward the neuron MAC
// The master modport is the reader itself; the slave modport is whatever
// sits around it (controller, RAM and MAC).
interface weight_stream_reader_if
  import weight_stream_pkg::*;
#(
  parameter int AW = WEIGHT_AW,
  parameter int DW = WEIGHT_DW
) ();

  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr;
  logic          en;
  logic          we;
  logic [DW-1:0] di;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;
  logic [AW-1:0] w_idx;

  modport master (
    input  start, ram_do, w_ready,
    output busy, done, addr, en, we, di, w_data, w_valid, w_last, w_idx
  );

  modport slave (
    output start, ram_do, w_ready,
    input  busy, done, addr, en, we, di, w_data, w_valid, w_last, w_idx
  );

endinterface

// File: rtl/weight_stream_reader_skid_fifo.sv
// Two-entry FIFO that absorbs consumer backpressure behind the RAM read
// pipeline.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data this cycle (ignored only if full with no pop)
//   push_data  : entry to store
//   pop        : drop the head entry this cycle (ignored when empty)
//   head_data  : oldest entry, forced to zero while empty
//   head_valid : FIFO holds at least one entry
//   count      : number of stored entries, 0..2
// Simultaneous push and pop is legal at any occupancy.
module weight_skid_fifo
  import weight_stream_pkg::*;
#(
  parameter int W = WEIGHT_DW + WEIGHT_AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle; the slot being written is then the one being vacated.
  always_comb begin
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push_ok) - 2'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/weight_stream_reader.sv
// Read-side controller for one weight block RAM.
// A start pulse in IDLE sweeps the RAM from address 0 to DEPTH-1 and streams
// every word, in order, toward the neuron MAC over a valid/ready handshake.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : master side of weight_stream_reader_if (control, RAM read
//              port, weight stream)
// The RAM is never written: we and di are tied to zero.
module weight_stream_reader
  import weight_stream_pkg::*;
#(
  parameter int DEPTH = WEIGHT_DEPTH,
  parameter int AW    = WEIGHT_AW,
  parameter int DW    = WEIGHT_DW
) (
  input logic                    clk,
  input logic                    rst,
  weight_stream_reader_if.master bus
);

  localparam int            FW        = DW + AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] issue_cnt_q, issue_cnt_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [FW-1:0] push_word;
  logic [FW-1:0] head_word;
  logic          head_valid;
  logic [1:0]    fifo_count;
  logic          pop;
  logic [2:0]    occupancy;
  logic          can_issue;

  // en_q doubles as the in-flight flag: a read issued this cycle lands in the
  // FIFO at the closing edge, tagged with the address it was issued on.
  assign push_word = {bus.ram_do, addr_q, (addr_q == LAST_ADDR)};
  assign pop       = head_valid && bus.w_ready;

  // Words already buffered plus the one in flight, minus the one leaving now,
  // must stay below two or the next read could find the FIFO full.
  assign occupancy = 3'(fifo_count) + 3'(en_q) - 3'(pop);
  assign can_issue = (occupancy < 3'd2);

  weight_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (en_q),
    .push_data  (push_word),
    .pop        (pop),
    .head_data  (head_word),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Sweep sequencing. The issue counter holds the next address to read; the
  // IDLE edge issues address 0 itself, so with DEPTH=1 the sweep goes straight
  // to DRAIN. DONE is raised for the cycle after the last word is accepted.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    en_d        = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d      = '0;
          en_d        = 1'b1;
          issue_cnt_d = AW'(1);
          state_d     = (DEPTH == 1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (can_issue) begin
          addr_d      = issue_cnt_q;
          en_d        = 1'b1;
          issue_cnt_d = issue_cnt_q + AW'(1);
          if (issue_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_word[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.en      = en_q;
  assign bus.we      = 1'b0;
  assign bus.di      = '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w_valid = head_valid;
  assign bus.w_data  = head_word[FW-1 -: DW];
  assign bus.w_idx   = head_word[1 +: AW];
  assign bus.w_last  = head_word[0];

endmodule

// File: tb/tb_weight_stream_reader.sv
// Testbench for weight_stream_reader: a DEPTH=28 instance and a DEPTH=1
// instance, each with a small RAM model that updates its output on the
// falling edge while enabled. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_weight_stream_reader;
  import weight_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  weight_stream_reader_if #(.AW(5), .DW(16)) bus_a ();
  weight_stream_reader_if #(.AW(1), .DW(16)) bus_b ();

  weight_stream_reader #(.DEPTH(28), .AW(5), .DW(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  weight_stream_reader #(.DEPTH(1), .AW(1), .DW(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [15:0] mem_a [0:31];
  logic [15:0] mem_b [0:1];

  always @(negedge clk) begin
    if (bus_a.en) bus_a.ram_do <= mem_a[bus_a.addr];
  end

  always @(negedge clk) begin
    if (bus_b.en) bus_b.ram_do <= mem_b[bus_b.addr];
  end

  int   num_checks = 0;
  int   num_fails  = 0;
  int   exp_idx    = 0;
  int   occ        = 0;
  int   max_occ    = 0;
  int   done_cnt   = 0;
  int   step       = 0;
  int   last_beat_step = 0;
  logic done_due   = 1'b0;
  int   en_b_cycles = 0;
  int   beats_b     = 0;
  int   done_b_cnt  = 0;
  int   beat_b_step = 0;
  int   done_b_step = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Per-cycle scoreboard, called at the falling edge. The head of the stream
  // must always be the next word of the sweep, whether or not it is accepted.
  task automatic observe();
    logic beat_a;
    logic beat_b;
    beat_a = bus_a.w_valid & bus_a.w_ready;
    beat_b = bus_b.w_valid & bus_b.w_ready;
    if (done_due) begin
      checkOutput("done_after_last", 32'(bus_a.done), 32'd1);
      done_due = 1'b0;
    end
    if (bus_a.done) done_cnt++;
    if (occ == 2 && !beat_a) checkOutput("en_low_when_full", 32'(bus_a.en), 32'd0);
    if (bus_a.w_valid) begin
      checkOutput("head_data", 32'(bus_a.w_data), 32'(16'h0100 + exp_idx));
      checkOutput("head_idx", 32'(bus_a.w_idx), 32'(exp_idx));
      checkOutput("head_last", 32'(bus_a.w_last), 32'(exp_idx == 27));
    end
    if (beat_a) begin
      if (exp_idx == 27) done_due = 1'b1;
      exp_idx++;
      last_beat_step = step;
    end
    occ = occ + int'(bus_a.en) - int'(beat_a);
    if (occ > max_occ) max_occ = occ;
    if (bus_b.en) en_b_cycles++;
    if (beat_b) begin
      checkOutput("b_idx", 32'(bus_b.w_idx), 32'd0);
      checkOutput("b_last", 32'(bus_b.w_last), 32'd1);
      checkOutput("b_data", 32'(bus_b.w_data), 32'h0000_A5A5);
      beats_b++;
      beat_b_step = step;
    end
    if (bus_b.done) begin
      done_b_cnt++;
      done_b_step = step;
    end
    step++;
  endtask

  task automatic applyStimulus(input logic start_a, input logic ready_a,
                               input logic start_b);
    bus_a.start   = start_a;
    bus_a.w_ready = ready_a;
    bus_b.start   = start_b;
    bus_b.w_ready = 1'b1;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: ready low for 10 cycles after start,
  // 2: random ready, 3: ready high with start pulses at beats 5 and 20.
  task automatic runSweep(input int mode, input string name);
    int   base_done;
    int   budget;
    int   start_step;
    logic rdy;
    logic st;
    base_done  = done_cnt;
    budget     = 0;
    exp_idx    = 0;
    start_step = step;
    rdy = (mode == 1) ? 1'b0 : 1'b1;
    applyStimulus(1'b1, rdy, 1'b0);
    if (mode == 0) begin
      checkOutput({name, "_first_en"}, 32'(bus_a.en), 32'd1);
      checkOutput({name, "_first_addr"}, 32'(bus_a.addr), 32'd0);
      checkOutput({name, "_first_valid"}, 32'(bus_a.w_valid), 32'd0);
      checkOutput({name, "_first_busy"}, 32'(bus_a.busy), 32'd1);
    end
    while (done_cnt == base_done && budget < 500) begin
      case (mode)
        1:       rdy = (budget >= 10);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      st = (mode == 3) && (exp_idx == 5 || exp_idx == 20);
      applyStimulus(st, rdy, 1'b0);
      if (mode == 1 && budget == 9) begin
        checkOutput("bp_captured", 32'(occ), 32'd2);
        checkOutput("bp_en", 32'(bus_a.en), 32'd0);
        checkOutput("bp_head_idx", 32'(bus_a.w_idx), 32'd0);
      end
      budget++;
    end
    if (done_cnt == base_done) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    checkOutput({name, "_beats"}, 32'(exp_idx), 32'd28);
    if (mode == 0) checkOutput({name, "_last_beat_cycle"}, 32'(last_beat_step - start_step), 32'd29);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput({name, "_busy_after"}, 32'(bus_a.busy), 32'd0);
    checkOutput({name, "_valid_after"}, 32'(bus_a.w_valid), 32'd0);
    checkOutput({name, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
    checkOutput({name, "_buffer_empty"}, 32'(occ), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int budget;
    for (int i = 0; i < 32; i++) mem_a[i] = 16'h0100 + 16'(i);
    mem_b[0] = 16'hA5A5;
    mem_b[1] = 16'h5A5A;
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_a.w_ready = 1'b0;
    bus_b.start = 1'b0;
    bus_b.w_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr", 32'(bus_a.addr), 32'd0);
    checkOutput("rst_en", 32'(bus_a.en), 32'd0);
    checkOutput("rst_we", 32'(bus_a.we), 32'd0);
    checkOutput("rst_di", 32'(bus_a.di), 32'd0);
    checkOutput("rst_valid", 32'(bus_a.w_valid), 32'd0);
    checkOutput("rst_last", 32'(bus_a.w_last), 32'd0);
    checkOutput("rst_idx", 32'(bus_a.w_idx), 32'd0);
    checkOutput("rst_data", 32'(bus_a.w_data), 32'd0);
    checkOutput("rst_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("rst_done", 32'(bus_a.done), 32'd0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("idle_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("idle_en", 32'(bus_a.en), 32'd0);

    runSweep(0, "full");
    runSweep(1, "backpressure");
    runSweep(2, "random0");
    runSweep(2, "random1");
    runSweep(2, "random2");
    runSweep(3, "start_busy");

    exp_idx = 0;
    budget  = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    while (exp_idx < 13 && budget < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      budget++;
    end
    checkOutput("midreset_reached_beat12", 32'(exp_idx), 32'd13);
    rst = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(bus_a.w_valid), 32'd0);
    checkOutput("midreset_en", 32'(bus_a.en), 32'd0);
    checkOutput("midreset_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("midreset_addr", 32'(bus_a.addr), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_idx  = 0;
    occ      = 0;
    done_due = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("postreset_idle_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("postreset_idle_en", 32'(bus_a.en), 32'd0);
    checkOutput("postreset_no_beats", 32'(exp_idx), 32'd0);
    runSweep(0, "post_reset");

    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("d1_first_en", 32'(bus_b.en), 32'd1);
    checkOutput("d1_first_addr", 32'(bus_b.addr), 32'd0);
    checkOutput("d1_first_busy", 32'(bus_b.busy), 32'd1);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("d1_beats", 32'(beats_b), 32'd1);
    checkOutput("d1_en_cycles", 32'(en_b_cycles), 32'd1);
    checkOutput("d1_done_count", 32'(done_b_cnt), 32'd1);
    checkOutput("d1_done_delay", 32'(done_b_step - beat_b_step), 32'd1);
    checkOutput("d1_busy_after", 32'(bus_b.busy), 32'd0);

    checkOutput("max_buffer_le_2", 32'(max_occ <= 2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/weight_stream_reader.md
# weight_stream_reader

Read-side controller for one weight block RAM of the ANN datapath. On a START pulse it sweeps the RAM from address 0 to DEPTH-1 and delivers each 16-bit weight, in order, on a valid/ready stream to the neuron MAC. Backpressure is absorbed by a 2-entry buffer, so the RAM read pipeline never loses a word. The block never writes the RAM: WE and DI are driven constant 0.

## Interface
- DEPTH, 28: number of weight words per sweep (≥1)
- AW, 5: RAM address width; must satisfy 2^AW ≥ DEPTH
- DW, 16: weight word width
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  begin a sweep; sampled only in IDLE
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  one-cycle pulse at sweep completion
- ADDR  out  AW  RAM address, registered
- EN  out  1  RAM enable, registered; high only for cycles issuing a read
- WE  out  1  constant 0
- DI  out  DW  constant 0
- DO  in  DW  RAM read data; the RAM updates it on negedge CLK when EN=1
- W_DATA  out  DW  weight word at head of buffer
- W_VALID  out  1  buffer non-empty
- W_READY  in  1  consumer accepts; beat = W_VALID & W_READY at posedge
- W_LAST  out  1  head word is address DEPTH-1
- W_IDX  out  AW  address of head word

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - START=1 → RUN.
  - On the same edge: ADDR<=0, EN<=1, issue counter <= 1.
- RUN:
  - Each cycle, issue a read when credit allows. Issuing sets ADDR<=next address and EN<=1. A cycle without an issue sets EN<=0 and holds ADDR.
  - After address DEPTH-1 is issued → DRAIN.
- DRAIN:
  - EN=0.
  - When the W_LAST beat is accepted → IDLE. DONE=1 for exactly that following cycle.
- Capture: if EN was 1 during cycle k, DO is pushed into the buffer at the posedge ending cycle k, tagged with that ADDR.
- Credit rule: issue only if (buffer count + in-flight read − pop this cycle) < 2. This guarantees no overflow and allows one beat per cycle with W_READY held high.
- Buffer is a 2-entry FIFO. Simultaneous push and pop is legal at any count.
- START while BUSY is ignored, and no second sweep is queued.
- W_DATA, W_IDX and W_LAST are stable while W_VALID=1 and W_READY=0.

## Timing
- Reset values: ADDR=0, EN=0, WE=0, DI=0, W_VALID=0, W_LAST=0, W_IDX=0, W_DATA=0, BUSY=0, DONE=0. The buffer is emptied, the FSM goes to IDLE, and the counters are cleared.
- START sampled at posedge t0:
  - EN=1 with ADDR=0 during cycle t0.
  - Word 0 is captured at t0+1, so W_VALID is high from t0+1.
- W_READY held high: words 0..DEPTH-1 are accepted at posedges t0+2 .. t0+DEPTH+1. DONE is high in the cycle after t0+DEPTH+1.
- RST asserted mid-sweep:
  - All outputs reach their reset values immediately. An in-flight RAM read is discarded.
  - After release, the block waits for a new START.
- DEPTH=1: the sweep is a single beat, with W_LAST=1 on it.

## Structure
- Package weight_stream_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - default constants WEIGHT_DEPTH=28, WEIGHT_AW=5, WEIGHT_DW=16.
- Sub-module weight_skid_fifo:
  - 2-entry FIFO, width DW+AW+1 (data, idx, last);
  - push/pop/count interface, async active-high reset.
- The top contains the FSM, the issue counter, the credit logic and the in-flight flag.

## Test plan
- Full sweep: RAM preloaded with word i = 16'h0100+i, W_READY=1, START pulse.
  - Expect 28 beats with W_DATA 0x0100..0x011B in order and W_IDX 0..27.
  - W_LAST only on the 28th beat; DONE one cycle after it; BUSY low afterwards.
- Backpressure: W_READY=0 for 10 cycles after START.
  - Expect at most 2 words captured and EN=0 while the buffer is full.
  - After release, still exactly 28 in-order beats with no duplicates or gaps.
- Random ready: W_READY driven 50% random, 3 consecutive sweeps.
  - Each sweep yields an in-order 0..27 sequence.
  - The buffer count never exceeds 2 (assertion); DONE fires once per sweep.
- START during busy: pulse START at beat 5 and beat 20.
  - Sweep is unaffected; only one DONE; no restart at address 0.
- Reset mid-sweep: assert RST after beat 12.
  - W_VALID, EN and BUSY go to 0 immediately.
  - A new START then produces a full 0..27 sweep.
- DEPTH=1 instance: START.
  - Expect a single beat with idx 0 and W_LAST=1, DONE on the next cycle, and EN high for exactly one cycle.
